// File: rtl/sram_like_arbiter_pkg.sv
// Shared CPU-side SRAM interface constants: source IDs and access-size encoding.
package sram_like_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per accepted-but-unanswered request.
module id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_id = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-port (instruction/data) to one-master SRAM-like arbiter with fixed data priority
// and in-order response routing through an ID FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  logic fifo_full, fifo_empty, head_id;
  logic grant_data, grant_inst;
  logic push, pop;

  // Full blocks grant even when a pop happens the same cycle.
  assign grant_data = data_sram_req & ~fifo_full & ~reset;
  assign grant_inst = inst_sram_req & ~fifo_full & ~reset & ~grant_data;

  always_comb begin
    sram_req   = 1'b0;
    sram_wr    = 1'b0;
    sram_size  = 2'd0;
    sram_wstrb = 4'd0;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (grant_data) begin
      sram_req   = 1'b1;
      sram_wr    = data_sram_wr;
      sram_size  = data_sram_size;
      sram_wstrb = data_sram_wstrb;
      sram_addr  = data_sram_addr;
      sram_wdata = data_sram_wdata;
    end else if (grant_inst) begin
      sram_req  = 1'b1;
      sram_size = SIZE_WORD;
      sram_addr = inst_sram_addr;
    end
  end

  assign data_sram_addr_ok = sram_addr_ok & grant_data;
  assign inst_sram_addr_ok = sram_addr_ok & grant_inst;

  assign push = sram_req & sram_addr_ok;
  // Responses with nothing outstanding are dropped.
  assign pop  = sram_data_ok & ~fifo_empty & ~reset;

  assign inst_sram_data_ok = pop & (head_id == SRC_INST);
  assign data_sram_data_ok = pop & (head_id == SRC_DATA);
  assign inst_sram_rdata   = reset ? 32'd0 : sram_rdata;
  assign data_sram_rdata   = reset ? 32'd0 : sram_rdata;

  id_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (grant_data ? SRC_DATA : SRC_INST),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (DEPTH=4).
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .DEPTH (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .sram_req          (sram_req),
    .sram_wr           (sram_wr),
    .sram_size         (sram_size),
    .sram_wstrb        (sram_wstrb),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_addr_ok      (sram_addr_ok),
    .sram_data_ok      (sram_data_ok),
    .sram_rdata        (sram_rdata)
  );

  // Inputs change on the falling edge; checks happen 1ns later, well before the rising edge.
  task automatic idle();
    @(negedge clk);
    inst_sram_req   = 1'b0;
    inst_sram_addr  = 32'd0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'd0;
    data_sram_addr  = 32'd0;
    data_sram_wdata = 32'd0;
    sram_addr_ok    = 1'b0;
    sram_data_ok    = 1'b0;
    sram_rdata      = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    sram_addr_ok  = 1'b1;
    sram_data_ok  = 1'b1;
    sram_rdata    = 32'h1234_5678;
    #1;
    total++;
    if ({sram_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}
        !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshakes got=%b exp=00000", {sram_req, inst_sram_addr_ok,
               data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    total++;
    if ({inst_sram_rdata, data_sram_rdata, sram_addr} !== 96'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", inst_sram_rdata, data_sram_rdata, sram_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (dut.u_fifo.count_q !== 3'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", dut.u_fifo.count_q);
    end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_priority();
    idle();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1000;
    data_sram_req  = 1'b1;
    data_sram_size = 2'd2;
    data_sram_addr = 32'h2000;
    sram_addr_ok   = 1'b1;
    #1;
    total++;
    if ({data_sram_addr_ok, inst_sram_addr_ok, sram_addr} !== {2'b10, 32'h2000}) begin
      bad++;
      $display("FAIL prio_grant got=%b%b addr=%h exp=10 addr=00002000",
               data_sram_addr_ok, inst_sram_addr_ok, sram_addr);
    end
    idle();
    sram_data_ok = 1'b1;
    sram_rdata   = 32'h55;
    #1;
    total++;
    if ({data_sram_data_ok, inst_sram_data_ok, data_sram_rdata} !== {2'b10, 32'h55}) begin
      bad++;
      $display("FAIL prio_head got=%b%b rdata=%h exp=10 rdata=00000055",
               data_sram_data_ok, inst_sram_data_ok, data_sram_rdata);
    end
  endtask

  task automatic test_in_order();
    idle();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1000;
    sram_addr_ok   = 1'b1;
    #1;
    total++;
    if ({inst_sram_addr_ok, sram_req, sram_wr, sram_addr} !== {3'b110, 32'h1000}) begin
      bad++;
      $display("FAIL order_inst_acc got=%b%b%b addr=%h exp=110 addr=00001000",
               inst_sram_addr_ok, sram_req, sram_wr, sram_addr);
    end
    idle();
    data_sram_req  = 1'b1;
    data_sram_size = 2'd2;
    data_sram_addr = 32'h2000;
    sram_addr_ok   = 1'b1;
    #1;
    total++;
    if ({data_sram_addr_ok, sram_addr} !== {1'b1, 32'h2000}) begin
      bad++;
      $display("FAIL order_data_acc got=%b addr=%h exp=1 addr=00002000",
               data_sram_addr_ok, sram_addr);
    end
    idle();
    sram_data_ok = 1'b1;
    sram_rdata   = 32'hAAAA;
    #1;
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'hAAAA}) begin
      bad++;
      $display("FAIL order_first got=%b%b rdata=%h exp=10 rdata=0000aaaa",
               inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
    end
    idle();
    sram_data_ok = 1'b1;
    sram_rdata   = 32'hBBBB;
    #1;
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok, data_sram_rdata} !== {2'b01, 32'hBBBB}) begin
      bad++;
      $display("FAIL order_second got=%b%b rdata=%h exp=01 rdata=0000bbbb",
               inst_sram_data_ok, data_sram_data_ok, data_sram_rdata);
    end
  endtask

  task automatic test_full();
    logic [3:0] exp_heads;
    for (int i = 0; i < 4; i++) begin
      idle();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h100 + 32'(i * 4);
      sram_addr_ok   = 1'b1;
      #1;
      total++;
      if (inst_sram_addr_ok !== 1'b1) begin
        bad++;
        $display("FAIL full_fill%0d got=%b exp=1", i, inst_sram_addr_ok);
      end
    end
    idle();
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    sram_addr_ok  = 1'b1;
    #1;
    total++;
    if ({sram_req, inst_sram_addr_ok, data_sram_addr_ok, dut.u_fifo.count_q} !== {3'b000, 3'd4})
    begin
      bad++;
      $display("FAIL full_block got=%b%b%b cnt=%0d exp=000 cnt=4", sram_req, inst_sram_addr_ok,
               data_sram_addr_ok, dut.u_fifo.count_q);
    end
    sram_data_ok = 1'b1;
    #1;
    total++;
    if ({sram_req, data_sram_addr_ok, inst_sram_data_ok} !== 3'b001) begin
      bad++;
      $display("FAIL full_pop_only got=%b%b%b exp=001", sram_req, data_sram_addr_ok,
               inst_sram_data_ok);
    end
    @(negedge clk);
    sram_data_ok = 1'b0;
    #1;
    total++;
    if ({sram_req, data_sram_addr_ok, dut.u_fifo.count_q} !== {2'b11, 3'd3}) begin
      bad++;
      $display("FAIL full_resume got=%b%b cnt=%0d exp=11 cnt=3", sram_req, data_sram_addr_ok,
               dut.u_fifo.count_q);
    end
    exp_heads = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      idle();
      sram_data_ok = 1'b1;
      #1;
      total++;
      if ({data_sram_data_ok, inst_sram_data_ok} !== {exp_heads[i], ~exp_heads[i]}) begin
        bad++;
        $display("FAIL full_drain%0d got=%b%b exp=%b%b", i, data_sram_data_ok,
                 inst_sram_data_ok, exp_heads[i], ~exp_heads[i]);
      end
    end
  endtask

  task automatic test_empty_data_ok();
    idle();
    sram_data_ok = 1'b1;
    sram_rdata   = 32'hCAFE;
    #1;
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL empty_dok got=%b%b exp=00", inst_sram_data_ok, data_sram_data_ok);
    end
    @(posedge clk);
    #1;
    total++;
    if (dut.u_fifo.count_q !== 3'd0) begin
      bad++;
      $display("FAIL empty_count got=%0d exp=0", dut.u_fifo.count_q);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      idle();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h500;
      sram_addr_ok   = 1'b1;
    end
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (dut.u_fifo.count_q !== 3'd0) begin
      bad++;
      $display("FAIL rstmid_count got=%0d exp=0", dut.u_fifo.count_q);
    end
    sram_data_ok = 1'b1;
    #1;
    total++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_dok got=%b%b exp=00", inst_sram_data_ok, data_sram_data_ok);
    end
  endtask

  task automatic test_write_fields();
    idle();
    #1;
    total++;
    if ({sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata} !== 72'd0) begin
      bad++;
      $display("FAIL nogrant_fields got=%b%b%h%h%h%h exp=0", sram_req, sram_wr, sram_size,
               sram_wstrb, sram_addr, sram_wdata);
    end
    idle();
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd1;
    data_sram_wstrb = 4'b0011;
    data_sram_addr  = 32'h3000;
    data_sram_wdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata}
        !== {1'b1, 1'b1, 2'd1, 4'b0011, 32'h3000, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL write_fields got=%b%b %0d %b %h %h exp=11 1 0011 00003000 deadbeef",
               sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata);
    end
    idle();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h4000;
    #1;
    total++;
    if ({sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata}
        !== {1'b1, 1'b0, 2'd2, 4'b0000, 32'h4000, 32'h0}) begin
      bad++;
      $display("FAIL inst_fields got=%b%b %0d %b %h %h exp=10 2 0000 00004000 00000000",
               sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_in_order();
    test_full();
    test_empty_data_ok();
    test_reset_mid();
    test_write_fields();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, maximum outstanding accepted-but-unanswered transactions (power of two, >=2).
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_sram_req  in  1  instruction-port request (read only).
REQ-005 inst_sram_addr  in  32  instruction fetch address; size fixed at 2'd2.
REQ-006 inst_sram_addr_ok  out  1  instruction address handshake.
REQ-007 inst_sram_data_ok  out  1  instruction read data valid.
REQ-008 inst_sram_rdata  out  32  instruction read data.
REQ-009 data_sram_req / data_sram_wr  in  1 / 1  data-port request and write flag.
REQ-010 data_sram_size / data_sram_wstrb  in  2 / 4  data access size and byte strobes.
REQ-011 data_sram_addr / data_sram_wdata  in  32 / 32  data address and write data.
REQ-012 data_sram_addr_ok / data_sram_data_ok  out  1 / 1  data handshakes.
REQ-013 data_sram_rdata  out  32  data read data.
REQ-014 sram_req, sram_wr, sram_size[1:0], sram_wstrb[3:0], sram_addr[31:0], sram_wdata[31:0]  out  shared master request.
REQ-015 sram_addr_ok, sram_data_ok, sram_rdata[31:0]  in  shared master responses.

Function
REQ-016 Grant SHALL be combinational, fixed priority: data port over instruction port; a request is eligible only when ID FIFO not full.
REQ-017 Master request fields SHALL equal the granted port's fields (inst: wr=0, size=2, wstrb=0, wdata=0); no grant -> sram_req=0, other fields 0.
REQ-018 <port>_addr_ok SHALL equal sram_addr_ok AND sram_req AND granted==port; zero-cycle latency.
REQ-019 On accepted handshake (sram_req & sram_addr_ok) the granted source ID (0=inst, 1=data) SHALL be pushed into an in-order ID FIFO of DEPTH entries.
REQ-020 sram_data_ok with FIFO non-empty SHALL assert data_ok only on the head-ID port that cycle, pop the head, and route sram_rdata to that port's rdata; both rdata outputs SHALL carry sram_rdata unconditionally.
REQ-021 Simultaneous push and pop SHALL both occur, count unchanged; push with FIFO full SHALL never occur (grant blocked even if a pop happens that cycle).
REQ-022 sram_data_ok with FIFO empty SHALL be ignored: no port data_ok, no state change.
REQ-023 Grant MAY switch between cycles before handshake; requesters hold fields stable until their addr_ok.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits, range 0..DEPTH.

Reset
REQ-025 While reset=1, all outputs SHALL be 0; on the next clk edge FIFO pointers and count SHALL clear to 0.
REQ-026 Reset mid-transaction SHALL discard all outstanding IDs; later data_ok for them is treated as REQ-022.

Structure
REQ-027 Source ID constants (SRC_INST=0, SRC_DATA=1) and size encoding SHALL live in the shared CPU interface package.
REQ-028 ID FIFO SHALL be a sub-module id_fifo (DEPTH, 1-bit width, push/pop/full/empty).

Verification
REQ-029 inst_req=1, data_req=1, addr_ok=1 one cycle -> data_addr_ok=1, inst_addr_ok=0, sram_addr=data_sram_addr, FIFO head=1.
REQ-030 Inst read 0x1000 accepted, then data read 0x2000; data_ok with rdata 0xAAAA then 0xBBBB -> inst gets 0xAAAA, data gets 0xBBBB, in order.
REQ-031 DEPTH=4, four accepted requests, no data_ok -> fifth request sees sram_req=0, both addr_ok=0; data_ok with new req same cycle -> pop only, next cycle grant resumes.
REQ-032 sram_data_ok=1 with FIFO empty -> inst_data_ok=0, data_data_ok=0, count stays 0.
REQ-033 Two outstanding, reset pulsed one cycle -> count=0, following sram_data_ok produces no port data_ok.
REQ-034 Data write addr 0x3000, wstrb 4'b0011, size 1 -> master mirrors fields exactly; inst request fields show wr=0, size=2, wstrb=0.
